// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: checker state encoding and reference 2-input truth tables
package gate_tt_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;
endpackage

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: checks observed gate outputs against a latched truth table with coverage tracking
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int N_IN = 2,
    localparam int TT_W = 2**N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TT_W-1:0]   exp_tt,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [N_IN-1:0]   vec_in,
    input  logic              vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [TT_W-1:0]   fail_map,
    output logic              proto_err
);
    state_t            state_q, state_d;
    logic [TT_W-1:0]   exp_q, seen_q, seen_n, fail_n, hot;
    logic [N_IN:0]     err_n;
    logic              run, acc, dup, bad, proto_n, fin;

    always_comb begin
        run     = state_q == RUN;
        hot     = TT_W'(1) << vec_in;
        acc     = run && vec_valid;
        dup     = seen_q[vec_in];
        bad     = acc && !dup && (vec_out != exp_q[vec_in]);
        seen_n  = acc ? (seen_q | hot) : seen_q;
        fail_n  = bad ? (fail_map | hot) : fail_map;
        err_n   = err_count + (N_IN+1)'(bad);
        proto_n = proto_err | (acc && dup) | (run && abort);
        // a transfer in the abort cycle is still recorded before finishing
        fin     = run && (abort || &seen_n);
        state_d = run ? (fin ? DONE : RUN) : (start ? RUN : state_q);
    end

    assign vec_ready = run;
    assign busy      = run;
    assign done      = state_q == DONE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            exp_q     <= '0;
            seen_q    <= '0;
            fail_map  <= '0;
            err_count <= '0;
            proto_err <= 1'b0;
            pass      <= 1'b0;
        end else if (!run && start) begin
            exp_q     <= exp_tt;
            seen_q    <= '0;
            fail_map  <= '0;
            err_count <= '0;
            proto_err <= 1'b0;
            pass      <= 1'b0;
        end else if (run) begin
            seen_q    <= seen_n;
            fail_map  <= fail_n;
            err_count <= err_n;
            proto_err <= proto_n;
            if (fin) pass <= (err_n == '0) && !proto_n;
        end
endmodule
